// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive controller: controller state
// encoding and prescale limits.
package uart_rx_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF = 2'd0,
    ST_ARM = 2'd1,
    ST_RUN = 2'd2
  } rx_state_e;

  localparam int PRESC_DEFAULT = 16;
  localparam int PRESC_MIN     = 4;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Byte stream from the receive FIFO to the host: valid/ready handshake.
interface uart_rx_ctrl_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx_ctrl_sync_fifo.sv
// Synchronous FIFO with a registered head word. Pointers carry one extra
// wrap bit so full/empty fall out of a plain compare. A push into a full
// FIFO is accepted only when a pop frees a slot in the same cycle.
module uart_rx_ctrl_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              push_ok_o,
  output logic              pop_ok_o,
  output logic              ovf_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] head_q, head_d;
  logic              empty, full, push_ok, pop_ok;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_ok  = pop_i && !empty;
  assign push_ok = push_i && (!full || pop_ok);

  // pointer advance and next head word (bypass when the new byte becomes head)
  always_comb begin
    wr_d   = wr_q + {{AW{1'b0}}, push_ok};
    rd_d   = rd_q + {{AW{1'b0}}, pop_ok};
    head_d = mem_q[rd_d[AW-1:0]];
    if (push_ok && (wr_q[AW-1:0] == rd_d[AW-1:0])) head_d = din_i;
  end

  // storage write; contents need no reset because the head is tracked separately
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  // pointers and head register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      head_q <= head_d;
    end
  end

  assign dout_o    = head_q;
  assign empty_o   = empty;
  assign full_o    = full;
  assign push_ok_o = push_ok;
  assign pop_ok_o  = pop_ok;
  assign ovf_o     = push_i && full && !pop_ok;
endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: OFF/ARM/RUN sequencing around the receiver
// datapath, byte FIFO onto a valid/ready stream, sticky error flags, idle
// timeout and a registered interrupt.
// Optional build macro UART_RX_ERRCNT_EN adds saturating 8-bit parity and
// stop error counters (err_cnt_par_o, err_cnt_stp_o).
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PRESC_W    = 5,
  parameter int FIFO_DEPTH = 8,
  parameter int ARM_BITS   = 10,
  parameter int TMO_BITS   = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_en_i,
  input  logic [PRESC_W-1:0] cfg_prescale_i,
  input  logic               cfg_par_en_i,
  input  logic               cfg_par_typ_i,
  input  logic               rx_pin_i,
  output logic               rx_line_o,
  output logic [PRESC_W-1:0] rx_prescale_o,
  output logic               rx_par_en_o,
  output logic               rx_par_typ_o,
  input  logic [DATA_W-1:0]  rx_pdata_i,
  input  logic               rx_dvalid_i,
  input  logic               rx_par_err_i,
  input  logic               rx_stp_err_i,
  uart_rx_ctrl_if.master     m_if,
  input  logic               sts_clr_i,
  output logic               sts_ovr_o,
  output logic               sts_par_o,
  output logic               sts_stp_o,
  output logic               rx_tmo_o,
  output logic               irq_o
`ifdef UART_RX_ERRCNT_EN
  ,
  output logic [7:0]         err_cnt_par_o,
  output logic [7:0]         err_cnt_stp_o
`endif
);
  localparam int IDLE_W = $clog2(ARM_BITS + 1);
  localparam int TMO_W  = $clog2(TMO_BITS + 1);
  localparam logic [IDLE_W-1:0]  ARM_LIM  = IDLE_W'(ARM_BITS);
  localparam logic [TMO_W-1:0]   TMO_LIM  = TMO_W'(TMO_BITS);
  localparam logic [PRESC_W-1:0] P_MIN    = PRESC_W'(PRESC_MIN);
  localparam logic [PRESC_W-1:0] P_DEF    = PRESC_W'(PRESC_DEFAULT);
  localparam logic [PRESC_W-1:0] P_ONE    = PRESC_W'(1);

  rx_state_e          state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               par_en_q, par_en_d, par_typ_q, par_typ_d;
  logic [PRESC_W-1:0] bit_tmr_q, bit_tmr_d;
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               rx_line_q;
  logic               sts_ovr_q, sts_par_q, sts_stp_q;
  logic               irq_q;
  logic               bit_wrap, run;
  logic               push, push_ok, pop_ok, ovf, empty, full;
  logic [DATA_W-1:0]  head;
  logic               par_set, stp_set, rx_tmo;

  assign run      = (state_q == ST_RUN);
  assign bit_wrap = (bit_tmr_q == presc_q - P_ONE);

  // next state: OFF arms on enable, ARM runs once the line has idled long enough
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_OFF:  if (cfg_en_i) state_d = ST_ARM;
      ST_ARM:  if (idle_cnt_d == ARM_LIM) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_OFF;
    endcase
    if (!cfg_en_i) state_d = ST_OFF;
  end

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_OFF;
    else       state_q <= state_d;
  end

  // bit-time timer and idle-line counter; a low line restarts both while arming
  always_comb begin
    bit_tmr_d  = bit_wrap ? '0 : bit_tmr_q + P_ONE;
    idle_cnt_d = idle_cnt_q;
    if (state_q == ST_OFF) begin
      bit_tmr_d  = '0;
      idle_cnt_d = '0;
    end else if (state_q == ST_ARM) begin
      if (!rx_pin_i) begin
        bit_tmr_d  = '0;
        idle_cnt_d = '0;
      end else if (bit_wrap && idle_cnt_q != ARM_LIM) begin
        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
      end
    end
  end

  // receiver config tracks the inputs only while OFF; prescale clamped to its minimum
  always_comb begin
    presc_d   = presc_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    if (state_q == ST_OFF) begin
      presc_d   = (cfg_prescale_i < P_MIN) ? P_MIN : cfg_prescale_i;
      par_en_d  = cfg_par_en_i;
      par_typ_d = cfg_par_typ_i;
    end
  end

  // idle timeout: whole bit-times in RUN with data waiting and no FIFO traffic
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (push_ok || pop_ok || empty)                  tmo_cnt_d = '0;
    else if (run && bit_wrap && tmo_cnt_q != TMO_LIM) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
  end

  // timers, config and the gated line
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_tmr_q  <= '0;
      idle_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      presc_q    <= P_DEF;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      rx_line_q  <= 1'b1;
    end else begin
      bit_tmr_q  <= bit_tmr_d;
      idle_cnt_q <= idle_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      presc_q    <= presc_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      rx_line_q  <= (run && cfg_en_i) ? rx_pin_i : 1'b1;
    end
  end

  assign push = rx_dvalid_i && run;

  uart_rx_ctrl_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (push),
    .din_i     (rx_pdata_i),
    .pop_i     (m_if.ready),
    .dout_o    (head),
    .empty_o   (empty),
    .full_o    (full),
    .push_ok_o (push_ok),
    .pop_ok_o  (pop_ok),
    .ovf_o     (ovf)
  );

  assign par_set = run && rx_par_err_i;
  assign stp_set = run && rx_stp_err_i;
  assign rx_tmo  = (tmo_cnt_q == TMO_LIM);

  // sticky flags (a set in the same cycle as clear wins) and registered interrupt
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sts_ovr_q <= 1'b0;
      sts_par_q <= 1'b0;
      sts_stp_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      sts_ovr_q <= ovf     || (sts_ovr_q && !sts_clr_i);
      sts_par_q <= par_set || (sts_par_q && !sts_clr_i);
      sts_stp_q <= stp_set || (sts_stp_q && !sts_clr_i);
      irq_q     <= !empty || sts_ovr_q || sts_par_q || sts_stp_q || rx_tmo;
    end
  end

`ifdef UART_RX_ERRCNT_EN
  logic [7:0] err_par_q, err_par_d, err_stp_q, err_stp_d;

  // saturating error pulse counters; a pulse during clear counts as the first
  always_comb begin
    err_par_d = sts_clr_i ? 8'd0 : err_par_q;
    err_stp_d = sts_clr_i ? 8'd0 : err_stp_q;
    if (par_set && err_par_d != 8'hFF) err_par_d = err_par_d + 8'd1;
    if (stp_set && err_stp_d != 8'hFF) err_stp_d = err_stp_d + 8'd1;
  end

  // counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_par_q <= 8'd0;
      err_stp_q <= 8'd0;
    end else begin
      err_par_q <= err_par_d;
      err_stp_q <= err_stp_d;
    end
  end

  assign err_cnt_par_o = err_par_q;
  assign err_cnt_stp_o = err_stp_q;
`endif

  assign m_if.data     = head;
  assign m_if.valid    = !empty;
  assign rx_line_o     = rx_line_q;
  assign rx_prescale_o = presc_q;
  assign rx_par_en_o   = par_en_q;
  assign rx_par_typ_o  = par_typ_q;
  assign sts_ovr_o     = sts_ovr_q;
  assign sts_par_o     = sts_par_q;
  assign sts_stp_o     = sts_stp_q;
  assign rx_tmo_o      = rx_tmo;
  assign irq_o         = irq_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: reset/config checks, arming latency probes,
// a vector table for FIFO/flag corners, a timeout sequence and a
// randomized phase against a queue-based reference model.
module tb_uart_rx_ctrl;
  localparam int DATA_W   = 8;
  localparam int PRESC_W  = 5;
  localparam int DEPTH    = 8;
  localparam int ARM_BITS = 10;
  localparam int TMO_BITS = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, cfg_en, cfg_par_en, cfg_par_typ, rx_pin;
  logic [PRESC_W-1:0] cfg_prescale;
  logic [7:0]         rx_pdata;
  logic               rx_dvalid, rx_par_err, rx_stp_err, sts_clr;
  logic               rx_line, rx_par_en, rx_par_typ;
  logic [PRESC_W-1:0] rx_prescale;
  logic               sts_ovr, sts_par, sts_stp, rx_tmo, irq;

  uart_rx_ctrl_if #(.DATA_W(DATA_W)) m_if ();

  uart_rx_ctrl #(
    .DATA_W(DATA_W), .PRESC_W(PRESC_W), .FIFO_DEPTH(DEPTH),
    .ARM_BITS(ARM_BITS), .TMO_BITS(TMO_BITS)
  ) dut (
    .clk_i(clk), .rst_i(rst), .cfg_en_i(cfg_en), .cfg_prescale_i(cfg_prescale),
    .cfg_par_en_i(cfg_par_en), .cfg_par_typ_i(cfg_par_typ), .rx_pin_i(rx_pin),
    .rx_line_o(rx_line), .rx_prescale_o(rx_prescale), .rx_par_en_o(rx_par_en),
    .rx_par_typ_o(rx_par_typ), .rx_pdata_i(rx_pdata), .rx_dvalid_i(rx_dvalid),
    .rx_par_err_i(rx_par_err), .rx_stp_err_i(rx_stp_err), .m_if(m_if),
    .sts_clr_i(sts_clr), .sts_ovr_o(sts_ovr), .sts_par_o(sts_par),
    .sts_stp_o(sts_stp), .rx_tmo_o(rx_tmo), .irq_o(irq)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       dv; logic [7:0] d; logic rdy, pe, se, clr;
    logic       ev; logic [7:0] eh; logic eo, ep, es, ei;
  } vec_t;
  vec_t vt [23];

  function automatic vec_t mk(input logic dv, input logic [7:0] d, input logic rdy,
                              input logic pe, input logic se, input logic clr,
                              input logic ev, input logic [7:0] eh, input logic eo,
                              input logic ep, input logic es, input logic ei);
    vec_t v;
    v.dv = dv; v.d = d; v.rdy = rdy; v.pe = pe; v.se = se; v.clr = clr;
    v.ev = ev; v.eh = eh; v.eo = eo; v.ep = ep; v.es = es; v.ei = ei;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rx_dvalid = 1'b0; rx_pdata = 8'h00; rx_par_err = 1'b0; rx_stp_err = 1'b0;
    sts_clr = 1'b0; m_if.ready = 1'b0; rx_pin = 1'b1;
  endtask

  task automatic do_reset();
    quiet();
    cfg_en = 1'b0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic arm(input int presc);
    cfg_prescale = presc[PRESC_W-1:0];
    cfg_en = 1'b1; rx_pin = 1'b1;
    repeat (ARM_BITS * presc + 2) step();
  endtask

  // Holds rx_dvalid high with data = edge index; the first byte to land in
  // the FIFO identifies the first edge at which the controller was in RUN.
  task automatic arm_probe(input int presc, input int low_at, output int first);
    first = -1;
    cfg_prescale = presc[PRESC_W-1:0];
    cfg_en = 1'b1; m_if.ready = 1'b0; rx_dvalid = 1'b1;
    for (int j = 0; j < 600 && first < 0; j++) begin
      rx_pdata = j[7:0];
      rx_pin   = (j == low_at) ? 1'b0 : 1'b1;
      step();
      if (m_if.valid) first = int'(m_if.data);
    end
    rx_dvalid = 1'b0; rx_pin = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         first, exp_first;
    logic [7:0] q [$];
    logic       mo, mp, ms, ei, pin_prev, pop;

    quiet();
    cfg_en = 1'b0; cfg_prescale = 5'd2; cfg_par_en = 1'b1; cfg_par_typ = 1'b1;
    rst = 1'b1;
    step(); step();
    chk("rst_rx_line",  32'(rx_line), 32'd1);
    chk("rst_presc",    32'(rx_prescale), 32'd16);
    chk("rst_par_en",   32'(rx_par_en), 32'd0);
    chk("rst_par_typ",  32'(rx_par_typ), 32'd0);
    chk("rst_m_valid",  32'(m_if.valid), 32'd0);
    chk("rst_m_data",   32'(m_if.data), 32'd0);
    chk("rst_sts",      32'({sts_ovr, sts_par, sts_stp}), 32'd0);
    chk("rst_tmo",      32'(rx_tmo), 32'd0);
    chk("rst_irq",      32'(irq), 32'd0);
    rst = 1'b0;
    step();
    chk("off_presc_clamp", 32'(rx_prescale), 32'd4);
    chk("off_par_en",      32'(rx_par_en), 32'd1);
    chk("off_par_typ",     32'(rx_par_typ), 32'd1);
    cfg_prescale = 5'd5;
    step();
    chk("off_presc_track", 32'(rx_prescale), 32'd5);
    cfg_par_en = 1'b0; cfg_par_typ = 1'b0;

    // arming latency with a steady idle line
    arm_probe(16, -1, first);
    exp_first = ARM_BITS * 16 + 1;
    chk("arm_latency", 32'(first), 32'(exp_first));
    cfg_prescale = 5'd9;
    step();
    chk("run_cfg_frozen", 32'(rx_prescale), 32'd16);
    rx_pin = 1'b0;
    step();
    chk("run_line_follow", 32'(rx_line), 32'd0);
    cfg_en = 1'b0;
    step();
    chk("off_line_high", 32'(rx_line), 32'd1);
    chk("off_fifo_kept", 32'(m_if.valid), 32'd1);
    step();
    chk("off_cfg_relatch", 32'(rx_prescale), 32'd9);
    rx_pin = 1'b1;

    // a low glitch during arming restarts the idle count
    do_reset();
    arm_probe(16, 5 * 16 + 3, first);
    exp_first = 5 * 16 + 3 + ARM_BITS * 16 + 1;
    chk("arm_restart", 32'(first), 32'(exp_first));

    // vector table: fill/overrun, full push+pop, drain, sticky flags
    for (int i = 0; i < 8; i++)
      vt[i] = mk(1, 8'(i + 1), 0, 0, 0, 0, 1, 8'h01, 0, 0, 0, i != 0);
    vt[8]  = mk(1, 8'h09, 0, 0, 0, 0, 1, 8'h01, 1, 0, 0, 1);
    vt[9]  = mk(0, 8'h00, 0, 0, 0, 1, 1, 8'h01, 0, 0, 0, 1);
    vt[10] = mk(1, 8'hAA, 1, 0, 0, 0, 1, 8'h02, 0, 0, 0, 1);
    for (int i = 11; i < 18; i++)
      vt[i] = mk(0, 8'h00, 1, 0, 0, 0, 1, (i < 17) ? 8'(i - 8) : 8'hAA, 0, 0, 0, 1);
    vt[18] = mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1);
    vt[19] = mk(0, 8'h00, 0, 1, 0, 1, 0, 8'h00, 0, 1, 0, 0);
    vt[20] = mk(0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 1, 1, 1);
    vt[21] = mk(0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 1);
    vt[22] = mk(0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    do_reset();
    arm(4);
    for (int i = 0; i < 23; i++) begin
      rx_dvalid = vt[i].dv; rx_pdata = vt[i].d; m_if.ready = vt[i].rdy;
      rx_par_err = vt[i].pe; rx_stp_err = vt[i].se; sts_clr = vt[i].clr;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(m_if.valid), 32'(vt[i].ev));
      if (vt[i].ev) chk($sformatf("vec%0d_data", i), 32'(m_if.data), 32'(vt[i].eh));
      chk($sformatf("vec%0d_flags", i), 32'({sts_ovr, sts_par, sts_stp}),
          32'({vt[i].eo, vt[i].ep, vt[i].es}));
      chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(vt[i].ei));
    end
    quiet();

    // idle timeout with one byte waiting
    do_reset();
    arm(8);
    rx_dvalid = 1'b1; rx_pdata = 8'h5A;
    step();
    rx_dvalid = 1'b0;
    chk("tmo_byte_valid", 32'(m_if.valid), 32'd1);
    repeat ((TMO_BITS - 1) * 8) step();
    chk("tmo_not_yet", 32'(rx_tmo), 32'd0);
    repeat (8) step();
    chk("tmo_set", 32'(rx_tmo), 32'd1);
    m_if.ready = 1'b1;
    step();
    m_if.ready = 1'b0;
    chk("tmo_pop_clear", 32'(rx_tmo), 32'd0);
    chk("tmo_pop_empty", 32'(m_if.valid), 32'd0);

    // randomized traffic against a queue model
    do_reset();
    arm(4);
    q.delete();
    mo = 1'b0; mp = 1'b0; ms = 1'b0;
    for (int n = 0; n < 300; n++) begin
      rx_dvalid  = ($urandom % 2) == 1;
      rx_pdata   = 8'($urandom);
      m_if.ready = ($urandom % 2) == 1;
      rx_par_err = ($urandom % 16) == 0;
      rx_stp_err = ($urandom % 16) == 0;
      sts_clr    = ($urandom % 8) == 0;
      rx_pin     = ($urandom % 2) == 1;
      pin_prev   = rx_pin;
      ei  = (q.size() != 0) || mo || mp || ms;
      pop = m_if.ready && (q.size() != 0);
      mo  = (rx_dvalid && q.size() == DEPTH && !pop) || (mo && !sts_clr);
      mp  = rx_par_err || (mp && !sts_clr);
      ms  = rx_stp_err || (ms && !sts_clr);
      if (pop) void'(q.pop_front());
      if (rx_dvalid && q.size() < DEPTH) q.push_back(rx_pdata);
      step();
      chk("rnd_valid", 32'(m_if.valid), 32'(q.size() != 0));
      if (q.size() != 0) chk("rnd_data", 32'(m_if.data), 32'(q[0]));
      chk("rnd_flags", 32'({sts_ovr, sts_par, sts_stp}), 32'({mo, mp, ms}));
      chk("rnd_irq", 32'(irq), 32'(ei));
      chk("rnd_line", 32'(rx_line), 32'(pin_prev));
    end
    quiet();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
